voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter FREQ_W, default 12, width of note frequency code (matches mixer freq inputs).
REQ-002 SHALL have parameter AGE_W, default 8, width of per-voice age counter.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, note request present.
REQ-006 SHALL have port req_ready, output, 1, allocator can accept a request this cycle.
REQ-007 SHALL have port req_on, input, 1, 1 = note-on, 0 = note-off.
REQ-008 SHALL have port req_freq, input, FREQ_W, frequency code of request.
REQ-009 SHALL have port all_off, input, 1, silence all voices.
REQ-010 SHALL have ports freq1, freq2, freq3, freq4, output, FREQ_W each, per-channel frequency code to mixer; 0 = voice free/muted.
REQ-011 SHALL have port active, output, 4, bit n-1 set when freqn nonzero.
REQ-012 SHALL have port steal, output, 1, one-cycle pulse when a sounding voice is reassigned.
REQ-013 SHALL have port drop, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL handshake: request accepted on rising edge where req_valid and req_ready are both 1; req_op/req_freq sampled on that edge only.
REQ-015 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; req_ready = 1 only in IDLE and not all_off.
REQ-016 SHALL move IDLE -> SCAN on acceptance, SCAN -> COMMIT and COMMIT -> IDLE unconditionally one cycle each.
REQ-017 SHALL in SCAN register per-voice match (freqn == captured freq), free (freqn == 0) flags and oldest-voice index.
REQ-018 SHALL in COMMIT update freq outputs, ages, steal and drop; new freq values visible the cycle after COMMIT edge (3 edges after acceptance edge).
REQ-019 SHALL on note-on with freq 0 or 1 (reserved mute codes) change no voice and pulse drop in COMMIT.
REQ-020 SHALL on note-on whose freq already sounds on voice n: keep freqn, set age n to 0 (retrigger), no steal.
REQ-021 SHALL otherwise on note-on assign freq to lowest-index free voice, its age = 0.
REQ-022 SHALL when no voice free steal voice with largest age (ties -> lowest index), write freq, age = 0, pulse steal.
REQ-023 SHALL on every committed note-on (not dropped) increment age of every other active voice, saturating at 2^AGE_W-1.
REQ-024 SHALL on note-off clear every voice whose freq equals req_freq (freq and age to 0); no match = no-op, no drop; note-off freq 0 = no-op.
REQ-025 SHALL on all_off (sampled each edge, highest priority) clear all freq/age to 0, return FSM to IDLE discarding in-flight request, suppress steal/drop that cycle.
REQ-026 SHALL hold steal and drop low except the single cycle after COMMIT edge.
REQ-027 SHALL never hold the same nonzero freq on two voices.

Reset
REQ-028 SHALL on reset assertion immediately force FSM IDLE, freq1..freq4 = 0, ages = 0, active = 0, steal = 0, drop = 0; req_ready = 0 while reset high, 1 on first cycle after release.
REQ-029 SHALL discard any in-flight request when reset asserts mid-operation.

Verification
REQ-030 SHALL cover: after reset, note-on 440, 220, 330, 550 back-to-back -> freq1..4 = 440,220,330,550, active = 4'b1111, no steal; each accept spaced 3 cycles (req_ready low 2 cycles each).
REQ-031 SHALL cover: all four full (ages 3,2,1,0), note-on 660 -> freq1 = 660, steal pulses once; then note-on 770 -> replaces freq2 (220).
REQ-032 SHALL cover: note-on 330 while 330 sounding on voice 3 -> freqs unchanged, age3 = 0, no steal; next full-bank note-on does not steal voice 3.
REQ-033 SHALL cover: note-on freq 1 and freq 0 -> drop pulses, freqs unchanged; note-off 999 (not sounding) -> no change, no drop.
REQ-034 SHALL cover: note-off 220 -> freq2 = 0, active[1] = 0; next note-on 880 -> lands on voice 2.
REQ-035 SHALL cover: all_off or reset asserted during SCAN of a note-on -> all freqs 0, no steal/drop, req_ready 1 next cycle (all_off) or after release (reset); ages saturate at 255 after 300 commits.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator
// Four-voice note allocator that sits in front of a four-channel mixer.
// Each request is handled in three steps: IDLE accepts it, SCAN records
// which voices match the frequency, which are free and which is oldest,
// and COMMIT updates the voice bank.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  a note request is present
//   req_ready  a request can be accepted this cycle (IDLE and not all_off)
//   req_on     1 = note-on, 0 = note-off
//   req_freq   frequency code of the request
//   all_off    silence every voice and abort any request in flight
//   freq1..4   per-channel frequency code to the mixer (0 = free/muted)
//   active     bit n-1 is set while freqn is nonzero
//   steal      one-cycle pulse when a sounding voice is reassigned
//   drop       one-cycle pulse when a note-on is rejected (code 0 or 1)
module voice_allocator #(
    parameter int FREQ_W = 12,
    parameter int AGE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_on,
    input  logic [FREQ_W-1:0] req_freq,
    input  logic              all_off,
    output logic [FREQ_W-1:0] freq1,
    output logic [FREQ_W-1:0] freq2,
    output logic [FREQ_W-1:0] freq3,
    output logic [FREQ_W-1:0] freq4,
    output logic [3:0]        active,
    output logic              steal,
    output logic              drop
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_SCAN   = 2'd1;
    localparam logic [1:0]       S_COMMIT = 2'd2;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_ready;
    logic              w_accept;
    logic              w_scan;
    logic              w_commit;

    logic              r_req_on;
    logic [FREQ_W-1:0] r_req_freq;
    logic [FREQ_W-1:0] r_freq [4];
    logic [AGE_W-1:0]  r_age  [4];
    logic [3:0]        r_match;
    logic [3:0]        r_free;
    logic [1:0]        r_oldest;
    logic              r_steal;
    logic              r_drop;

    logic [3:0]        w_match;
    logic [3:0]        w_free;
    logic [1:0]        w_oldest;
    logic [1:0]        w_free_idx;
    logic [1:0]        w_match_idx;
    logic [1:0]        w_target;
    logic              w_reserved;
    logic              w_on_ok;
    logic              w_off_ok;
    logic [FREQ_W-1:0] w_freq_next [4];
    logic [AGE_W-1:0]  w_age_next  [4];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (all_off) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_SCAN;
            S_SCAN:   w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // reset is folded in so ready stays low for as long as reset is held.
    always_comb begin
        w_ready  = (r_state == S_IDLE) && !all_off && !reset;
        w_scan   = (r_state == S_SCAN);
        w_commit = (r_state == S_COMMIT);
    end

    assign req_ready = w_ready;
    assign w_accept  = req_valid && w_ready;

    // ---------------- per-voice flags and outputs ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_voice
            assign w_match[gi] = (r_freq[gi] == r_req_freq);
            assign w_free[gi]  = (r_freq[gi] == '0);
            assign active[gi]  = (r_freq[gi] != '0);

            assign w_freq_next[gi] =
                (w_on_ok && (w_target == 2'(gi))) ? r_req_freq :
                (w_off_ok && r_match[gi])         ? '0         :
                                                    r_freq[gi];

            // Every committed note-on ages the other sounding voices.
            assign w_age_next[gi] =
                (w_on_ok && (w_target == 2'(gi)))   ? '0 :
                (w_on_ok && (r_freq[gi] != '0) && (r_age[gi] != AGE_MAX))
                                                    ? r_age[gi] + AGE_W'(1) :
                (w_off_ok && r_match[gi])           ? '0 :
                                                      r_age[gi];
        end
    endgenerate

    assign freq1 = r_freq[0];
    assign freq2 = r_freq[1];
    assign freq3 = r_freq[2];
    assign freq4 = r_freq[3];
    assign steal = r_steal;
    assign drop  = r_drop;

    // Oldest voice: strict '>' keeps the lowest index on ties.
    always_comb begin
        w_oldest = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (r_age[i] > r_age[w_oldest]) w_oldest = 2'(i);
        end
    end

    // Lowest-index free voice and the (unique) matching voice.
    always_comb begin
        w_free_idx  = 2'd0;
        w_match_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_free[i])  w_free_idx  = 2'(i);
            if (r_match[i]) w_match_idx = 2'(i);
        end
    end

    // Retrigger wins over a free voice, which wins over stealing.
    always_comb begin
        w_reserved = (r_req_freq <= FREQ_W'(1));
        w_on_ok    = w_commit && r_req_on && !w_reserved;
        w_off_ok   = w_commit && !r_req_on && (r_req_freq != '0);
        if (|r_match)     w_target = w_match_idx;
        else if (|r_free) w_target = w_free_idx;
        else              w_target = r_oldest;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_on   <= 1'b0;
            r_req_freq <= '0;
            r_match    <= '0;
            r_free     <= '0;
            r_oldest   <= 2'd0;
            r_steal    <= 1'b0;
            r_drop     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_freq[i] <= '0;
                r_age[i]  <= '0;
            end
        end else if (all_off) begin
            r_steal <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_freq[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_req_on   <= req_on;
                r_req_freq <= req_freq;
            end
            if (w_scan) begin
                r_match  <= w_match;
                r_free   <= w_free;
                r_oldest <= w_oldest;
            end
            r_steal <= w_on_ok && !(|r_match) && !(|r_free);
            r_drop  <= w_commit && r_req_on && w_reserved;
            for (int i = 0; i < 4; i++) begin
                r_freq[i] <= w_freq_next[i];
                r_age[i]  <= w_age_next[i];
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one linear stimulus sequence, every
// observation checked by an immediate assertion against hand-computed values.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_on;
    logic [11:0] req_freq;
    logic        all_off;
    logic [11:0] freq1, freq2, freq3, freq4;
    logic [3:0]  active;
    logic        steal;
    logic        drop;

    int n_checks = 0;
    int n_err    = 0;

    voice_allocator #(.FREQ_W(12), .AGE_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_on    (req_on),
        .req_freq  (req_freq),
        .all_off   (all_off),
        .freq1     (freq1),
        .freq2     (freq2),
        .freq3     (freq3),
        .freq4     (freq4),
        .active    (active),
        .steal     (steal),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag, input int e1, input int e2, input int e3, input int e4);
        logic [3:0] exp_act;
        exp_act = {e4 != 0, e3 != 0, e2 != 0, e1 != 0};
        chk({tag, ".freq1"}, 32'(freq1), 32'(e1));
        chk({tag, ".freq2"}, 32'(freq2), 32'(e2));
        chk({tag, ".freq3"}, 32'(freq3), 32'(e3));
        chk({tag, ".freq4"}, 32'(freq4), 32'(e4));
        chk({tag, ".active"}, 32'(active), 32'(exp_act));
        $display("bank %s: %0d %0d %0d %0d active=%b", tag, freq1, freq2, freq3, freq4, active);
    endtask

    // Wait (bounded) for req_ready, then present the request on the next edge.
    task automatic present(input logic on, input int f);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_on    = on;
        req_freq  = 12'(f);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full request: checks the busy window, the result pulses and their clearing.
    task automatic note(input logic on, input int f, input logic exp_steal, input logic exp_drop);
        present(on, f);
        chk("ready_in_scan", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_in_commit", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_commit", 32'(req_ready), 32'd1);
        chk("steal_pulse", 32'(steal), 32'(exp_steal));
        chk("drop_pulse", 32'(drop), 32'(exp_drop));
        $display("req on=%0d freq=%0d -> steal=%0d drop=%0d", on, f, steal, drop);
        @(posedge clk);
        #1;
        chk("steal_clear", 32'(steal), 32'd0);
        chk("drop_clear", 32'(drop), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_on    = 1'b0;
        req_freq  = '0;
        all_off   = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_steal", 32'(steal), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk_bank("rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 chk("ready_after_release", 32'(req_ready), 32'd1);

        // Fill the bank; ages end 3,2,1,0.
        note(1'b1, 440, 1'b0, 1'b0);
        chk_bank("fill1", 440, 0, 0, 0);
        note(1'b1, 220, 1'b0, 1'b0);
        note(1'b1, 330, 1'b0, 1'b0);
        note(1'b1, 550, 1'b0, 1'b0);
        chk_bank("fill4", 440, 220, 330, 550);

        // Steal oldest twice.
        note(1'b1, 660, 1'b1, 1'b0);
        chk_bank("steal660", 660, 220, 330, 550);
        note(1'b1, 770, 1'b1, 1'b0);
        chk_bank("steal770", 660, 770, 330, 550);

        // Retrigger 330 (voice 3 age 0), next steal takes voice 4 (age 3).
        note(1'b1, 330, 1'b0, 1'b0);
        chk_bank("retrig330", 660, 770, 330, 550);
        note(1'b1, 990, 1'b1, 1'b0);
        chk_bank("steal990", 660, 770, 330, 990);

        // Reserved codes are dropped; unmatched note-off is silent.
        note(1'b1, 1, 1'b0, 1'b1);
        note(1'b1, 0, 1'b0, 1'b1);
        chk_bank("reserved", 660, 770, 330, 990);
        note(1'b0, 999, 1'b0, 1'b0);
        chk_bank("off999", 660, 770, 330, 990);

        // Note-off frees voice 2, next note-on reuses it without stealing.
        note(1'b0, 770, 1'b0, 1'b0);
        chk_bank("off770", 660, 0, 330, 990);
        note(1'b1, 880, 1'b0, 1'b0);
        chk_bank("on880", 660, 880, 330, 990);

        // all_off while a note-on is in SCAN.
        present(1'b1, 123);
        all_off = 1'b1;
        #1 chk("ready_all_off", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_bank("all_off", 0, 0, 0, 0);
        chk("all_off_steal", 32'(steal), 32'd0);
        chk("all_off_drop", 32'(drop), 32'd0);
        all_off = 1'b0;
        #1 chk("ready_after_all_off", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk_bank("all_off_discard", 0, 0, 0, 0);

        // Age saturation: voice 1 sees 512 increments (wraps to 0 if not
        // saturated) while voice 2 ends at age 2, so voice 1 must be stolen.
        note(1'b1, 100, 1'b0, 1'b0);
        for (int k = 0; k < 510; k++) note(1'b1, 200, 1'b0, 1'b0);
        note(1'b1, 300, 1'b0, 1'b0);
        note(1'b1, 400, 1'b0, 1'b0);
        chk_bank("sat_full", 100, 200, 300, 400);
        note(1'b1, 500, 1'b1, 1'b0);
        chk_bank("sat_steal", 500, 200, 300, 400);

        // Reset while a note-on is in SCAN.
        present(1'b1, 600);
        #2 reset = 1'b1;
        #1;
        chk_bank("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_steal", 32'(steal), 32'd0);
        chk("rst_mid_drop", 32'(drop), 32'd0);
        @(negedge clk) reset = 1'b0;
        #1 chk("ready_after_rst_mid", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk_bank("rst_mid_discard", 0, 0, 0, 0);

        // Note-off 220 then note-on 880 lands on voice 2.
        note(1'b1, 440, 1'b0, 1'b0);
        note(1'b1, 220, 1'b0, 1'b0);
        note(1'b0, 220, 1'b0, 1'b0);
        chk_bank("off220", 440, 0, 0, 0);
        note(1'b1, 880, 1'b0, 1'b0);
        chk_bank("reuse_v2", 440, 880, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
